// File: rtl/nv_nvdla_csc_accu_credit_if.sv
// Sequencer <-> credit tracker bundle.
//   slave  : credit tracker side (takes layer control, CACC credit returns and
//            stripe requests; drives grant, credit count and status)
//   master : sequencer / CACC side (the mirror image)
interface nv_nvdla_csc_accu_credit_if #(
  parameter int CNT_W  = 8,
  parameter int COST_W = 4
);
  logic              op_en;
  logic              layer_end;
  logic              accu2sc_credit_vld;
  logic [2:0]        accu2sc_credit_size;
  logic              req_pvld;
  logic [COST_W-1:0] req_cost;
  logic              req_prdy;
  logic [CNT_W-1:0]  credit_cnt;
  logic              layer_done;
  logic              credit_ovf_err;
  logic              cost_err;
  logic              busy;

  modport slave (
    input  op_en, layer_end, accu2sc_credit_vld, accu2sc_credit_size,
           req_pvld, req_cost,
    output req_prdy, credit_cnt, layer_done, credit_ovf_err, cost_err, busy
  );

  modport master (
    output op_en, layer_end, accu2sc_credit_vld, accu2sc_credit_size,
           req_pvld, req_cost,
    input  req_prdy, credit_cnt, layer_done, credit_ovf_err, cost_err, busy
  );
endinterface

// File: rtl/nv_nvdla_csc_accu_credit.sv
// CSC-side credit tracker for the CACC assembly buffer.
// Holds the count of free CACC output entries, grants stripe issue only when
// the stripe's cost is covered, and at layer end drains until every credit
// has come back before pulsing layer_done.
// Ports:
//   nvdla_core_clk   core clock
//   nvdla_core_rstn  async active-low reset
//   bus (slave)      op_en/layer_end control, accu2sc credit return,
//                    req_pvld/req_cost/req_prdy issue handshake,
//                    credit_cnt, layer_done, credit_ovf_err, cost_err, busy
module nv_nvdla_csc_accu_credit #(
  parameter int CREDIT_MAX = 128,
  parameter int CNT_W      = 8,
  parameter int COST_W     = 4
) (
  input  logic                            nvdla_core_clk,
  input  logic                            nvdla_core_rstn,
  nv_nvdla_csc_accu_credit_if.slave       bus
);

  // Arithmetic width wide enough for either operand plus one carry bit.
  localparam int SW = ((CNT_W > COST_W) ? CNT_W : COST_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_ovf;
  logic             r_cerr;
  logic             r_busy;

  logic [SW-1:0]    w_max;
  logic [SW-1:0]    w_cost;
  logic [SW-1:0]    w_ret;
  logic [SW-1:0]    w_sum;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cost_bad;
  logic             w_prdy;
  logic             w_accept;
  logic             w_ovf;

  assign w_max      = SW'(CREDIT_MAX);
  assign w_cost     = SW'(bus.req_cost);
  assign w_ret      = bus.accu2sc_credit_vld ? SW'(bus.accu2sc_credit_size) : '0;
  assign w_cost_bad = (w_cost > w_max);

  // Grant looks only at the registered count, so a credit returned this
  // cycle is usable from the next cycle on.
  assign w_prdy   = (r_state == ST_RUN) && (SW'(r_cnt) >= w_cost) && !w_cost_bad;
  assign w_accept = bus.req_pvld & w_prdy;

  // Accept and return in the same cycle are both applied; the accept can
  // never underflow because it requires r_cnt >= cost.
  assign w_sum     = SW'(r_cnt) - (w_accept ? w_cost : '0) + w_ret;
  assign w_ovf     = (w_sum > w_max);
  assign w_cnt_nxt = w_ovf ? CNT_W'(CREDIT_MAX) : w_sum[CNT_W-1:0];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_W'(CREDIT_MAX);
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cerr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_done <= 1'b0;
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end
      if (bus.req_pvld && w_cost_bad) begin
        r_cerr <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.op_en) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.layer_end) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_cnt_nxt == CNT_W'(CREDIT_MAX)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_prdy       = w_prdy;
  assign bus.credit_cnt     = r_cnt;
  assign bus.layer_done     = r_done;
  assign bus.credit_ovf_err = r_ovf;
  assign bus.cost_err       = r_cerr;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_nv_nvdla_csc_accu_credit.sv
module tb_nv_nvdla_csc_accu_credit;

  localparam int CMAX = 128;

  logic clk;
  logic rstn;

  int checks;
  int errors;

  // Reference model: free credits as a plain integer, layer phase as 0/1/2
  // (idle / issuing / waiting for credits), sticky flags as bits.
  int m_cnt;
  int m_mode;
  bit m_ovf;
  bit m_cerr;
  bit m_done;
  bit m_acc;

  nv_nvdla_csc_accu_credit_if #(.CNT_W(8), .COST_W(4)) bus ();
  nv_nvdla_csc_accu_credit_if #(.CNT_W(4), .COST_W(4)) bus8 ();

  nv_nvdla_csc_accu_credit #(.CREDIT_MAX(128), .CNT_W(8), .COST_W(4)) u_dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus)
  );

  nv_nvdla_csc_accu_credit #(.CREDIT_MAX(8), .CNT_W(4), .COST_W(4)) u_dut8 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_cnt  = CMAX;
    m_mode = 0;
    m_ovf  = 1'b0;
    m_cerr = 1'b0;
    m_done = 1'b0;
    m_acc  = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.op_en = 1'b0;  bus.layer_end = 1'b0;
    bus.accu2sc_credit_vld = 1'b0;  bus.accu2sc_credit_size = 3'd0;
    bus.req_pvld = 1'b0;  bus.req_cost = 4'd0;
    bus8.op_en = 1'b0;  bus8.layer_end = 1'b0;
    bus8.accu2sc_credit_vld = 1'b0;  bus8.accu2sc_credit_size = 3'd0;
    bus8.req_pvld = 1'b0;  bus8.req_cost = 4'd0;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    int nxt;
    int cost;
    bit acc;
    cost = int'(bus.req_cost);
    acc  = (m_mode == 1) && bus.req_pvld && (m_cnt >= cost);
    nxt  = m_cnt - (acc ? cost : 0)
         + (bus.accu2sc_credit_vld ? int'(bus.accu2sc_credit_size) : 0);
    if (bus.req_pvld && cost > CMAX) m_cerr = 1'b1;
    if (nxt > CMAX) begin
      nxt   = CMAX;
      m_ovf = 1'b1;
    end
    m_done = 1'b0;
    if (m_mode == 0) begin
      if (bus.op_en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.layer_end) m_mode = 2;
    end else if (nxt == CMAX) begin
      m_mode = 0;
      m_done = 1'b1;
    end
    m_cnt = nxt;
    m_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.credit_cnt !== 8'd128) begin errors++; $display("FAIL reset_cnt got %0d exp 128", bus.credit_cnt); end
    checks++; if (bus.req_prdy !== 1'b0) begin errors++; $display("FAIL reset_prdy got %b exp 0", bus.req_prdy); end
    checks++; if (bus.layer_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.layer_done); end
    checks++; if (bus.credit_ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.credit_ovf_err); end
    checks++; if (bus.cost_err !== 1'b0) begin errors++; $display("FAIL reset_cerr got %b exp 0", bus.cost_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus8.credit_cnt !== 4'd8) begin errors++; $display("FAIL reset_cnt8 got %0d exp 8", bus8.credit_cnt); end
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    int accepts;
    bit exp_prdy;
    bus.op_en = 1'b1;
    tick();
    bus.op_en = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %b exp 1", bus.busy); end
    accepts = 0;
    bus.req_pvld = 1'b1;
    bus.req_cost = 4'd8;
    for (int i = 0; i < 16; i++) begin
      exp_prdy = (m_mode == 1) && (m_cnt >= 8);
      checks++; if (bus.req_prdy !== exp_prdy) begin errors++; $display("FAIL fill_prdy[%0d] got %b exp %b", i, bus.req_prdy, exp_prdy); end
      if (bus.req_prdy === 1'b1) accepts++;
      tick();
    end
    checks++; if (accepts != 16) begin errors++; $display("FAIL fill_accepts got %0d exp 16", accepts); end
    checks++; if (bus.credit_cnt !== 8'd0) begin errors++; $display("FAIL fill_cnt got %0d exp 0", bus.credit_cnt); end
    checks++; if (bus.req_prdy !== 1'b0) begin errors++; $display("FAIL fill_stall got %b exp 0", bus.req_prdy); end
    tick();
    checks++; if (bus.credit_cnt !== 8'(m_cnt) || m_cnt != 0) begin errors++; $display("FAIL fill_stall_cnt got %0d exp 0", bus.credit_cnt); end
  endtask

  task automatic test_return_latency();
    bus.req_pvld = 1'b1;
    bus.req_cost = 4'd4;
    checks++; if (bus.req_prdy !== 1'b0) begin errors++; $display("FAIL lat_pre got %b exp 0", bus.req_prdy); end
    bus.accu2sc_credit_vld  = 1'b1;
    bus.accu2sc_credit_size = 3'd5;
    #1;
    checks++; if (bus.req_prdy !== 1'b0) begin errors++; $display("FAIL lat_same_cycle got %b exp 0", bus.req_prdy); end
    tick();
    bus.accu2sc_credit_vld = 1'b0;
    #1;
    checks++; if (bus.req_prdy !== 1'b1) begin errors++; $display("FAIL lat_next_cycle got %b exp 1", bus.req_prdy); end
    tick();
    bus.req_pvld = 1'b0;
    checks++; if (bus.credit_cnt !== 8'd1) begin errors++; $display("FAIL lat_cnt got %0d exp 1", bus.credit_cnt); end
  endtask

  task automatic test_simultaneous();
    bus.accu2sc_credit_vld  = 1'b1;
    bus.accu2sc_credit_size = 3'd7;
    tick();
    bus.accu2sc_credit_size = 3'd2;
    tick();
    bus.accu2sc_credit_vld = 1'b0;
    checks++; if (bus.credit_cnt !== 8'd10) begin errors++; $display("FAIL simul_setup got %0d exp 10", bus.credit_cnt); end
    bus.req_pvld = 1'b1;
    bus.req_cost = 4'd6;
    bus.accu2sc_credit_vld  = 1'b1;
    bus.accu2sc_credit_size = 3'd7;
    #1;
    checks++; if (bus.req_prdy !== 1'b1) begin errors++; $display("FAIL simul_prdy got %b exp 1", bus.req_prdy); end
    tick();
    bus.req_pvld = 1'b0;
    bus.accu2sc_credit_vld = 1'b0;
    checks++; if (bus.credit_cnt !== 8'd11) begin errors++; $display("FAIL simul_cnt got %0d exp 11", bus.credit_cnt); end
  endtask

  task automatic test_drain();
    while (m_cnt < 120) begin
      bus.accu2sc_credit_vld  = 1'b1;
      bus.accu2sc_credit_size = 3'((120 - m_cnt) > 7 ? 7 : (120 - m_cnt));
      tick();
    end
    bus.accu2sc_credit_vld = 1'b0;
    checks++; if (bus.credit_cnt !== 8'd120) begin errors++; $display("FAIL drain_setup got %0d exp 120", bus.credit_cnt); end
    bus.layer_end = 1'b1;
    tick();
    bus.layer_end = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %b exp 1", bus.busy); end
    bus.accu2sc_credit_vld  = 1'b1;
    bus.accu2sc_credit_size = 3'd7;
    tick();
    checks++; if (bus.credit_cnt !== 8'd127) begin errors++; $display("FAIL drain_cnt127 got %0d exp 127", bus.credit_cnt); end
    checks++; if (bus.layer_done !== 1'b0) begin errors++; $display("FAIL drain_early_done got %b exp 0", bus.layer_done); end
    bus.accu2sc_credit_size = 3'd1;
    tick();
    bus.accu2sc_credit_vld = 1'b0;
    checks++; if (bus.credit_cnt !== 8'd128) begin errors++; $display("FAIL drain_cnt128 got %0d exp 128", bus.credit_cnt); end
    checks++; if (bus.layer_done !== 1'b1) begin errors++; $display("FAIL drain_done got %b exp 1", bus.layer_done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drain_idle got %b exp 0", bus.busy); end
    tick();
    checks++; if (bus.layer_done !== 1'b0) begin errors++; $display("FAIL drain_pulse got %b exp 0", bus.layer_done); end
  endtask

  task automatic test_overflow();
    bus.accu2sc_credit_vld  = 1'b1;
    bus.accu2sc_credit_size = 3'd3;
    tick();
    bus.accu2sc_credit_vld = 1'b0;
    checks++; if (bus.credit_cnt !== 8'd128) begin errors++; $display("FAIL ovf_cnt got %0d exp 128", bus.credit_cnt); end
    checks++; if (bus.credit_ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.credit_ovf_err); end
    repeat (5) tick();
    checks++; if (bus.credit_ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.credit_ovf_err); end
  endtask

  task automatic test_reset_midlayer();
    #2 rstn = 1'b0;
    #1 rstn = 1'b1;
    model_reset();
    checks++; if (bus.credit_ovf_err !== 1'b0) begin errors++; $display("FAIL rst_clr_ovf got %b exp 0", bus.credit_ovf_err); end
    bus.op_en = 1'b1;
    tick();
    bus.op_en = 1'b0;
    bus.req_pvld = 1'b1;
    bus.req_cost = 4'd8;
    repeat (11) tick();
    checks++; if (bus.credit_cnt !== 8'd40) begin errors++; $display("FAIL rst_setup got %0d exp 40", bus.credit_cnt); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.credit_cnt !== 8'd128) begin errors++; $display("FAIL rst_async_cnt got %0d exp 128", bus.credit_cnt); end
    checks++; if (bus.req_prdy !== 1'b0) begin errors++; $display("FAIL rst_async_prdy got %b exp 0", bus.req_prdy); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b exp 0", bus.busy); end
    bus.req_pvld = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    bus.op_en = 1'b1;
    tick();
    bus.op_en = 1'b0;
    bus.req_pvld = 1'b1;
    bus.req_cost = 4'd0;
    #1;
    checks++; if (bus.req_prdy !== 1'b1) begin errors++; $display("FAIL zero_cost_prdy got %b exp 1", bus.req_prdy); end
    tick();
    bus.req_pvld = 1'b0;
    checks++; if (bus.credit_cnt !== 8'd128) begin errors++; $display("FAIL zero_cost_cnt got %0d exp 128", bus.credit_cnt); end
    // Small-buffer instance: a cost above its capacity must stall and flag.
    bus8.op_en = 1'b1;
    tick();
    bus8.op_en = 1'b0;
    bus8.req_pvld = 1'b1;
    bus8.req_cost = 4'd9;
    #1;
    checks++; if (bus8.req_prdy !== 1'b0) begin errors++; $display("FAIL cost_prdy got %b exp 0", bus8.req_prdy); end
    tick();
    checks++; if (bus8.cost_err !== 1'b1) begin errors++; $display("FAIL cost_err got %b exp 1", bus8.cost_err); end
    checks++; if (bus8.credit_cnt !== 4'd8) begin errors++; $display("FAIL cost_cnt got %0d exp 8", bus8.credit_cnt); end
    checks++; if (bus8.req_prdy !== 1'b0) begin errors++; $display("FAIL cost_stall got %b exp 0", bus8.req_prdy); end
    bus8.req_pvld = 1'b0;
    checks++; if (bus.cost_err !== 1'b0) begin errors++; $display("FAIL cost_err_main got %b exp 0", bus.cost_err); end
  endtask

  task automatic test_random();
    bit exp_prdy;
    int dones;
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      bus.req_pvld            = ($urandom % 4) != 0;
      bus.req_cost            = 4'($urandom_range(0, 15));
      bus.accu2sc_credit_vld  = ($urandom % 2) != 0;
      bus.accu2sc_credit_size = 3'($urandom % 8);
      bus.layer_end           = ($urandom % 60) == 0;
      bus.op_en               = ($urandom % 20) == 0;
      #1;
      exp_prdy = (m_mode == 1) && (m_cnt >= int'(bus.req_cost));
      checks++; if (bus.req_prdy !== exp_prdy) begin errors++; $display("FAIL rnd_prdy[%0d] got %b exp %b", i, bus.req_prdy, exp_prdy); end
      tick();
      checks++; if (bus.credit_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, bus.credit_cnt, m_cnt); end
      checks++; if (bus.layer_done !== m_done) begin errors++; $display("FAIL rnd_done[%0d] got %b exp %b", i, bus.layer_done, m_done); end
      checks++; if (bus.busy !== (m_mode != 0)) begin errors++; $display("FAIL rnd_busy[%0d] got %b exp %b", i, bus.busy, m_mode != 0); end
      checks++; if (bus.credit_ovf_err !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %b exp %b", i, bus.credit_ovf_err, m_ovf); end
      checks++; if (bus.cost_err !== m_cerr) begin errors++; $display("FAIL rnd_cerr[%0d] got %b exp %b", i, bus.cost_err, m_cerr); end
      if (m_done) dones++;
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_fill();
    test_return_latency();
    test_simultaneous();
    test_drain();
    test_overflow();
    test_reset_midlayer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
